// File: rtl/wrap_fill_load_controller.sv
// Data-cache load-miss controller: hit/miss resolution, word-by-word dirty write-back,
// then a (optionally critical-word-first) refill with optional early restart to the load unit.
module wrap_fill_load_controller #(
   parameter int OFFSET         = 2,
   parameter int TAG            = 16,
   parameter int INDEX          = 12,
   parameter int CRITICAL_FIRST = 1,
   parameter int EARLY_RESTART  = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              stall_i,
   input  logic              invalidate_i,
   input  logic              request_i,
   input  logic [31:0]       address_i,
   output logic [31:0]       data_o,
   output logic              valid_o,
   output logic              busy_o,
   output logic              ld_request_o,
   input  logic              ld_ready_i,
   output logic [31:0]       ld_address_o,
   input  logic              ld_valid_i,
   input  logic [31:0]       ld_data_i,
   output logic              st_request_o,
   input  logic              st_ready_i,
   output logic [31:0]       st_address_o,
   output logic [31:0]       st_data_o,
   input  logic              cache_hit_i,
   input  logic              cache_dirty_i,
   input  logic [TAG-1:0]    cache_tag_i,
   input  logic [31:0]       cache_data_i,
   output logic [31:0]       cache_address_o,
   output logic              cache_read_data_o,
   output logic              cache_read_meta_o,
   output logic              cache_write_data_o,
   output logic              cache_write_meta_o,
   output logic [31:0]       cache_data_o,
   output logic              cache_valid_o,
   output logic              cache_dirty_o
);

   localparam int BLOCK_WORDS = 2 ** OFFSET;

   typedef enum logic [2:0] {IDLE, LOOKUP, WB_READ, WB_STORE, FILL} state_t;

   state_t              state_reg;
   logic [TAG-1:0]      victim_reg;
   logic [OFFSET-1:0]   k_reg;
   logic [OFFSET:0]     q_reg;
   logic [OFFSET:0]     r_reg;
   logic [31:0]         wb_data_reg;
   logic [31:0]         fwd_reg;
   logic                wb_first_reg;
   logic                pending_reg;

   logic [TAG-1:0]      req_tag;
   logic [INDEX-1:0]    req_index;
   logic [OFFSET-1:0]   req_word;
   logic [OFFSET-1:0]   start_word;
   logic [OFFSET-1:0]   q_word;
   logic [OFFSET-1:0]   r_word;
   logic [31:0]         wb_addr;
   logic [31:0]         fill_addr;
   logic [31:0]         resp_addr;
   logic                ld_accept;
   logic                st_accept;
   logic                last_resp;
   logic                is_fwd;
   logic                kill;

   assign req_tag    = address_i[31 -: TAG];
   assign req_index  = address_i[OFFSET+2 +: INDEX];
   assign req_word   = address_i[2 +: OFFSET];
   assign start_word = (CRITICAL_FIRST != 0) ? req_word : '0;
   // Word indices wrap naturally because the sum is truncated to OFFSET bits.
   assign q_word     = start_word + q_reg[OFFSET-1:0];
   assign r_word     = start_word + r_reg[OFFSET-1:0];
   assign wb_addr    = {victim_reg, req_index, k_reg, 2'b00};
   assign fill_addr  = {req_tag, req_index, q_word, 2'b00};
   assign resp_addr  = {req_tag, req_index, r_word, 2'b00};
   assign ld_accept  = ld_request_o & ld_ready_i;
   assign st_accept  = st_request_o & st_ready_i;
   assign last_resp  = (r_reg == (OFFSET+1)'(BLOCK_WORDS - 1));
   assign is_fwd     = (r_word == req_word);
   assign kill       = invalidate_i | pending_reg;
   assign busy_o     = (state_reg != IDLE);

   always_comb begin
      data_o             = '0;
      valid_o            = 1'b0;
      ld_request_o       = 1'b0;
      ld_address_o       = '0;
      st_request_o       = 1'b0;
      st_address_o       = '0;
      st_data_o          = '0;
      cache_address_o    = '0;
      cache_read_data_o  = 1'b0;
      cache_read_meta_o  = 1'b0;
      cache_write_data_o = 1'b0;
      cache_write_meta_o = 1'b0;
      cache_data_o       = '0;
      cache_valid_o      = 1'b0;
      cache_dirty_o      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rst_n_i) begin
               cache_address_o   = address_i;
               cache_read_data_o = request_i;
               cache_read_meta_o = request_i;
            end
         end
         LOOKUP: begin
            cache_address_o = address_i;
            if (cache_hit_i) begin
               data_o  = cache_data_i;
               valid_o = !invalidate_i;
            end else if (stall_i && !invalidate_i) begin
               // Re-read so the lookup outcome is still current when the stall lifts.
               cache_read_data_o = 1'b1;
               cache_read_meta_o = 1'b1;
            end
         end
         WB_READ: begin
            cache_address_o   = wb_addr;
            cache_read_data_o = 1'b1;
         end
         WB_STORE: begin
            cache_address_o = wb_addr;
            st_request_o    = !stall_i;
            st_address_o    = wb_addr;
            st_data_o       = wb_first_reg ? cache_data_i : wb_data_reg;
         end
         FILL: begin
            cache_address_o = resp_addr;
            ld_request_o    = !q_reg[OFFSET] && !stall_i;
            ld_address_o    = fill_addr;
            if (ld_valid_i) begin
               cache_write_data_o = 1'b1;
               cache_data_o       = ld_data_i;
               if (r_reg == '0) begin
                  cache_write_meta_o = 1'b1;
                  cache_valid_o      = 1'b1;
               end
               if (EARLY_RESTART != 0) begin
                  if (is_fwd) begin
                     data_o  = ld_data_i;
                     valid_o = !kill;
                  end
               end else if (last_resp) begin
                  data_o  = is_fwd ? ld_data_i : fwd_reg;
                  valid_o = !kill;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg    <= IDLE;
         victim_reg   <= '0;
         k_reg        <= '0;
         q_reg        <= '0;
         r_reg        <= '0;
         wb_data_reg  <= '0;
         fwd_reg      <= '0;
         wb_first_reg <= 1'b0;
         pending_reg  <= 1'b0;
      end else begin
         wb_first_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               pending_reg <= 1'b0;
               if (request_i) state_reg <= LOOKUP;
            end
            LOOKUP: begin
               if (cache_hit_i) begin
                  state_reg <= IDLE;
               end else begin
                  victim_reg <= cache_tag_i;
                  if (invalidate_i) begin
                     state_reg <= IDLE;
                  end else if (!stall_i) begin
                     k_reg     <= '0;
                     q_reg     <= '0;
                     r_reg     <= '0;
                     state_reg <= cache_dirty_i ? WB_READ : FILL;
                  end
               end
            end
            WB_READ: begin
               if (invalidate_i) pending_reg <= 1'b1;
               wb_first_reg <= 1'b1;
               state_reg    <= WB_STORE;
            end
            WB_STORE: begin
               if (wb_first_reg) wb_data_reg <= cache_data_i;
               if (invalidate_i) pending_reg <= 1'b1;
               if (st_accept) begin
                  k_reg <= k_reg + 1'b1;
                  // A flushed write-back stops after the in-flight word; the line stays dirty.
                  if (kill)              state_reg <= IDLE;
                  else if (k_reg == '1)  state_reg <= FILL;
                  else                   state_reg <= WB_READ;
               end
            end
            FILL: begin
               if (invalidate_i) pending_reg <= 1'b1;
               if (ld_accept) q_reg <= q_reg + 1'b1;
               if (ld_valid_i) begin
                  r_reg <= r_reg + 1'b1;
                  if (is_fwd) fwd_reg <= ld_data_i;
                  if (last_resp) state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wrap_fill_load_controller.sv
// Directed bench: instance a uses critical-word-first + early restart, instance b uses
// in-order fill + late restart; both share every input and run in lockstep.
module tb_wrap_fill_load_controller;

   localparam logic [31:0] K = 32'h5A5A_5A5A;   // cache model data = address ^ K
   localparam logic [31:0] M = 32'h1357_9BDF;   // memory model data = address ^ M

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        stall_i, invalidate_i, request_i;
   logic [31:0] address_i;
   logic        ld_ready_i, ld_valid_i, st_ready_i;
   logic [31:0] ld_data_i;
   logic        cache_hit_i, cache_dirty_i;
   logic [15:0] cache_tag_i;
   logic [31:0] cache_data_i;

   logic [31:0] data_o, ld_address_o, st_address_o, st_data_o, cache_address_o, cache_data_o;
   logic        valid_o, busy_o, ld_request_o, st_request_o;
   logic        cache_read_data_o, cache_read_meta_o, cache_write_data_o, cache_write_meta_o;
   logic        cache_valid_o, cache_dirty_o;

   logic [31:0] b_data_o, b_ld_address_o, b_st_address_o, b_st_data_o, b_cache_address_o, b_cache_data_o;
   logic        b_valid_o, b_busy_o, b_ld_request_o, b_st_request_o;
   logic        b_cache_read_data_o, b_cache_read_meta_o, b_cache_write_data_o, b_cache_write_meta_o;
   logic        b_cache_valid_o, b_cache_dirty_o;

   int n_checks = 0;
   int n_errors = 0;
   logic sel_b = 1'b0;
   logic resp_en = 1'b0;

   always #5 clk_i = ~clk_i;

   wrap_fill_load_controller #(.OFFSET(2), .TAG(16), .INDEX(12), .CRITICAL_FIRST(1), .EARLY_RESTART(1)) dut_a (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .invalidate_i(invalidate_i),
      .request_i(request_i), .address_i(address_i), .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o),
      .ld_request_o(ld_request_o), .ld_ready_i(ld_ready_i), .ld_address_o(ld_address_o),
      .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i),
      .st_request_o(st_request_o), .st_ready_i(st_ready_i), .st_address_o(st_address_o), .st_data_o(st_data_o),
      .cache_hit_i(cache_hit_i), .cache_dirty_i(cache_dirty_i), .cache_tag_i(cache_tag_i),
      .cache_data_i(cache_data_i), .cache_address_o(cache_address_o),
      .cache_read_data_o(cache_read_data_o), .cache_read_meta_o(cache_read_meta_o),
      .cache_write_data_o(cache_write_data_o), .cache_write_meta_o(cache_write_meta_o),
      .cache_data_o(cache_data_o), .cache_valid_o(cache_valid_o), .cache_dirty_o(cache_dirty_o));

   wrap_fill_load_controller #(.OFFSET(2), .TAG(16), .INDEX(12), .CRITICAL_FIRST(0), .EARLY_RESTART(0)) dut_b (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .invalidate_i(invalidate_i),
      .request_i(request_i), .address_i(address_i), .data_o(b_data_o), .valid_o(b_valid_o), .busy_o(b_busy_o),
      .ld_request_o(b_ld_request_o), .ld_ready_i(ld_ready_i), .ld_address_o(b_ld_address_o),
      .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i),
      .st_request_o(b_st_request_o), .st_ready_i(st_ready_i), .st_address_o(b_st_address_o), .st_data_o(b_st_data_o),
      .cache_hit_i(cache_hit_i), .cache_dirty_i(cache_dirty_i), .cache_tag_i(cache_tag_i),
      .cache_data_i(cache_data_i), .cache_address_o(b_cache_address_o),
      .cache_read_data_o(b_cache_read_data_o), .cache_read_meta_o(b_cache_read_meta_o),
      .cache_write_data_o(b_cache_write_data_o), .cache_write_meta_o(b_cache_write_meta_o),
      .cache_data_o(b_cache_data_o), .cache_valid_o(b_cache_valid_o), .cache_dirty_o(b_cache_dirty_o));

   // Transaction logs, appended on the active edge and only read by the stimulus.
   int          cyc = 0;
   int          ldreq_cnt = 0;
   int          streq_cnt = 0;
   logic [31:0] ld_log[$], st_alog[$], st_dlog[$], wr_alog[$], wr_dlog[$], meta_alog[$], v_dlog[$], bv_dlog[$];
   logic [1:0]  meta_vd[$];
   int          resp_cyc[$], v_cyc[$], bv_cyc[$];
   int          rd_ptr = 0;

   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      if (ld_request_o) ldreq_cnt <= ldreq_cnt + 1;
      if (st_request_o) streq_cnt <= streq_cnt + 1;
      if (sel_b ? (b_ld_request_o && ld_ready_i) : (ld_request_o && ld_ready_i))
         ld_log.push_back(sel_b ? b_ld_address_o : ld_address_o);
      if (st_request_o && st_ready_i) begin
         st_alog.push_back(st_address_o);
         st_dlog.push_back(st_data_o);
      end
      if (cache_write_data_o) begin
         wr_alog.push_back(cache_address_o);
         wr_dlog.push_back(cache_data_o);
      end
      if (cache_write_meta_o) begin
         meta_alog.push_back(cache_address_o);
         meta_vd.push_back({cache_valid_o, cache_dirty_o});
      end
      if (ld_valid_i) resp_cyc.push_back(cyc);
      if (valid_o) begin
         v_dlog.push_back(data_o);
         v_cyc.push_back(cyc);
      end
      if (b_valid_o) begin
         bv_dlog.push_back(b_data_o);
         bv_cyc.push_back(cyc);
      end
   end

   // Cache array model: registered read, data = address ^ K.
   always @(posedge clk_i) begin
      if (cache_read_data_o) cache_data_i <= cache_address_o ^ K;
   end

   // Memory model: answers each accepted load in order, one cycle later when enabled.
   always @(negedge clk_i) begin
      if (resp_en && rd_ptr < ld_log.size()) begin
         ld_valid_i <= 1'b1;
         ld_data_i  <= ld_log[rd_ptr] ^ M;
         rd_ptr     <= rd_ptr + 1;
      end else begin
         ld_valid_i <= 1'b0;
         ld_data_i  <= '0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic wait_idle(output int c);
      bit done;
      done = 1'b0;
      for (int n = 0; n < 60 && !done; n++) begin
         tick();
         if (!(sel_b ? b_busy_o : busy_o)) done = 1'b1;
      end
      c = cyc;
      check("idle_reached", 32'(done), 32'd1);
   endtask

   task automatic start_request(input logic [31:0] addr);
      address_i = addr;
      request_i = 1'b1;
      tick();
      request_i = 1'b0;
   endtask

   initial begin
      int ib, sb, wb, mb, vb, rb, bb, lq, sq, ic;
      rst_n_i = 1'b0; stall_i = 1'b0; invalidate_i = 1'b0; request_i = 1'b0; address_i = '0;
      ld_ready_i = 1'b0; st_ready_i = 1'b0; cache_hit_i = 1'b0; cache_dirty_i = 1'b0; cache_tag_i = '0;
      tick(); tick();
      check("rst_busy", 32'(busy_o), 0);
      check("rst_valid", 32'(valid_o), 0);
      check("rst_ld_req", 32'(ld_request_o), 0);
      check("rst_st_req", 32'(st_request_o), 0);
      check("rst_rd_en", 32'(cache_read_data_o), 0);
      rst_n_i = 1'b1;
      tick();

      // Hit
      lq = ldreq_cnt; sq = streq_cnt;
      address_i = 32'h0000_1238; cache_hit_i = 1'b1; request_i = 1'b1; #1;
      check("hit_rd_data", 32'(cache_read_data_o), 1);
      check("hit_rd_meta", 32'(cache_read_meta_o), 1);
      check("hit_caddr", cache_address_o, 32'h0000_1238);
      tick(); request_i = 1'b0;
      check("hit_valid", 32'(valid_o), 1);
      check("hit_data", data_o, 32'h0000_1238 ^ K);
      tick();
      check("hit_valid_gone", 32'(valid_o), 0);
      check("hit_busy_gone", 32'(busy_o), 0);
      check("hit_no_mem", 32'(ldreq_cnt - lq + streq_cnt - sq), 0);
      cache_hit_i = 1'b0;

      // Clean miss, offset 2, critical-word-first with early restart
      ib = ld_log.size(); wb = wr_alog.size(); mb = meta_alog.size(); vb = v_dlog.size();
      rb = resp_cyc.size(); sb = st_alog.size();
      cache_tag_i = 16'h1111; ld_ready_i = 1'b1; resp_en = 1'b1;
      start_request(32'h1234_5678);
      wait_idle(ic);
      check("cm_ld0", ld_log[ib],   32'h1234_5678);
      check("cm_ld1", ld_log[ib+1], 32'h1234_567C);
      check("cm_ld2", ld_log[ib+2], 32'h1234_5670);
      check("cm_ld3", ld_log[ib+3], 32'h1234_5674);
      check("cm_wr_cnt", 32'(wr_alog.size() - wb), 4);
      check("cm_wr0", wr_alog[wb], 32'h1234_5678);
      check("cm_wr3", wr_alog[wb+3], 32'h1234_5674);
      check("cm_wr0_data", wr_dlog[wb], 32'h1234_5678 ^ M);
      check("cm_meta_cnt", 32'(meta_alog.size() - mb), 1);
      check("cm_meta_addr", meta_alog[mb], 32'h1234_5678);
      check("cm_meta_vd", 32'(meta_vd[mb]), 32'd2);
      check("cm_valid_cnt", 32'(v_dlog.size() - vb), 1);
      check("cm_valid_data", v_dlog[vb], 32'h1234_5678 ^ M);
      check("cm_valid_at_first_resp", 32'(v_cyc[vb]), 32'(resp_cyc[rb]));
      check("cm_busy_drop", 32'(ic), 32'(resp_cyc[rb+3] + 1));
      check("cm_no_store", 32'(st_alog.size() - sb), 0);

      // Dirty miss with store backpressure
      ib = ld_log.size(); sb = st_alog.size();
      cache_dirty_i = 1'b1; cache_tag_i = 16'hBEEF; st_ready_i = 1'b0;
      start_request(32'h1234_5678);
      tick();
      check("wb_rd_en", 32'(cache_read_data_o), 1);
      check("wb_rd_addr", cache_address_o, 32'hBEEF_5670);
      tick();
      for (int i = 0; i < 3; i++) begin
         check("wb_hold_req", 32'(st_request_o), 1);
         check("wb_hold_addr", st_address_o, 32'hBEEF_5670);
         check("wb_hold_data", st_data_o, 32'hBEEF_5670 ^ K);
         tick();
      end
      st_ready_i = 1'b1; cache_dirty_i = 1'b0;
      wait_idle(ic);
      check("wb_st_cnt", 32'(st_alog.size() - sb), 4);
      check("wb_st0", st_alog[sb],   32'hBEEF_5670);
      check("wb_st1", st_alog[sb+1], 32'hBEEF_5674);
      check("wb_st2", st_alog[sb+2], 32'hBEEF_5678);
      check("wb_st3", st_alog[sb+3], 32'hBEEF_567C);
      check("wb_st1_data", st_dlog[sb+1], 32'hBEEF_5674 ^ K);
      check("wb_st3_data", st_dlog[sb+3], 32'hBEEF_567C ^ K);
      check("wb_fill_cnt", 32'(ld_log.size() - ib), 4);
      check("wb_fill0", ld_log[ib], 32'h1234_5678);

      // Memory backpressure plus stall in the middle of a fill
      ib = ld_log.size(); wb = wr_alog.size(); vb = v_dlog.size();
      start_request(32'h0000_ABC4);
      tick();
      check("bp_req_first", 32'(ld_request_o), 1);
      check("bp_addr_first", ld_address_o, 32'h0000_ABC4);
      tick();
      ld_ready_i = 1'b0; stall_i = 1'b1; #1;
      check("bp_stall_req", 32'(ld_request_o), 0);
      check("bp_stall_write", 32'(cache_write_data_o), 1);
      check("bp_stall_waddr", cache_address_o, 32'h0000_ABC4);
      stall_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp_held_req", 32'(ld_request_o), 1);
         check("bp_held_addr", ld_address_o, 32'h0000_ABC8);
      end
      ld_ready_i = 1'b1;
      wait_idle(ic);
      check("bp_ld_cnt", 32'(ld_log.size() - ib), 4);
      check("bp_ld1", ld_log[ib+1], 32'h0000_ABC8);
      check("bp_ld2", ld_log[ib+2], 32'h0000_ABCC);
      check("bp_ld3", ld_log[ib+3], 32'h0000_ABC0);
      check("bp_wr_cnt", 32'(wr_alog.size() - wb), 4);
      check("bp_valid_cnt", 32'(v_dlog.size() - vb), 1);
      check("bp_valid_data", v_dlog[vb], 32'h0000_ABC4 ^ M);

      // Flush in LOOKUP on a dirty miss
      lq = ldreq_cnt; sq = streq_cnt;
      cache_dirty_i = 1'b1;
      start_request(32'h0000_ABC4);
      invalidate_i = 1'b1; #1;
      check("inv_lk_valid", 32'(valid_o), 0);
      tick();
      invalidate_i = 1'b0; cache_dirty_i = 1'b0;
      check("inv_lk_idle", 32'(busy_o), 0);
      tick();
      check("inv_lk_no_mem", 32'(ldreq_cnt - lq + streq_cnt - sq), 0);

      // Flush during a fill
      ib = ld_log.size(); wb = wr_alog.size(); mb = meta_alog.size(); vb = v_dlog.size();
      resp_en = 1'b0;
      start_request(32'h0000_ABC4);
      tick();
      invalidate_i = 1'b1;
      tick();
      invalidate_i = 1'b0; resp_en = 1'b1;
      wait_idle(ic);
      check("inv_fill_ld_cnt", 32'(ld_log.size() - ib), 4);
      check("inv_fill_wr_cnt", 32'(wr_alog.size() - wb), 4);
      check("inv_fill_meta_cnt", 32'(meta_alog.size() - mb), 1);
      check("inv_fill_no_valid", 32'(v_dlog.size() - vb), 0);

      // Reset in the middle of a fill drops the pending request at once
      ld_ready_i = 1'b0;
      start_request(32'h0000_ABC4);
      tick();
      check("mid_rst_req_before", 32'(ld_request_o), 1);
      rst_n_i = 1'b0; #1;
      check("mid_rst_req", 32'(ld_request_o), 0);
      check("mid_rst_busy", 32'(busy_o), 0);
      check("mid_rst_busy_b", 32'(b_busy_o), 0);
      tick();
      rst_n_i = 1'b1;
      tick();

      // In-order fill with late restart (instance b), offset 1
      sel_b = 1'b1;
      ib = ld_log.size(); bb = bv_dlog.size(); rb = resp_cyc.size();
      ld_ready_i = 1'b1;
      start_request(32'h4321_0DE4);
      wait_idle(ic);
      check("ord_ld0", ld_log[ib],   32'h4321_0DE0);
      check("ord_ld1", ld_log[ib+1], 32'h4321_0DE4);
      check("ord_ld2", ld_log[ib+2], 32'h4321_0DE8);
      check("ord_ld3", ld_log[ib+3], 32'h4321_0DEC);
      check("ord_valid_cnt", 32'(bv_dlog.size() - bb), 1);
      check("ord_valid_data", bv_dlog[bb], 32'h4321_0DE4 ^ M);
      check("ord_valid_at_last", 32'(bv_cyc[bb]), 32'(resp_cyc[rb+3]));

      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
